// File: rtl/spi_peripheral_rw.sv
// SPI mode-0 register peripheral: write frames update a small register file,
// read frames shift a register back out on CIPO. Malformed frames are dropped.
module spi_peripheral_rw #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         SCLK,
  input  logic                         nCS,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic                         CIPO_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);

  localparam logic [CNT_W-1:0]  CNT_LEN      = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX      = CNT_W'(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_CMD_LAST = CNT_W'(ADDR_W);
  localparam logic [ADDR_W:0]   NUM_REGS_A   = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_WDATA  = 3'd2,
    S_RDATA  = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    in_range = ({1'b0, a} < NUM_REGS_A);
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
    onehot = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (a == ADDR_W'(k)) begin
        onehot[k] = 1'b1;
      end else begin
        onehot[k] = onehot[k];
      end
    end
  endfunction

  function automatic logic [DATA_W-1:0] reg_lookup(input logic [ADDR_W-1:0] a,
                                                   input logic [NUM_REGS*DATA_W-1:0] r);
    reg_lookup = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (a == ADDR_W'(k)) begin
        reg_lookup = r[k*DATA_W +: DATA_W];
      end else begin
        reg_lookup = reg_lookup;
      end
    end
  endfunction

  function automatic logic [NUM_REGS*DATA_W-1:0] reg_write(input logic [NUM_REGS*DATA_W-1:0] r,
                                                           input logic [ADDR_W-1:0] a,
                                                           input logic [DATA_W-1:0] d);
    reg_write = r;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (a == ADDR_W'(k)) begin
        reg_write[k*DATA_W +: DATA_W] = d;
      end else begin
        reg_write[k*DATA_W +: DATA_W] = r[k*DATA_W +: DATA_W];
      end
    end
  endfunction

  logic [2:0]                 sclk_q;
  logic [2:0]                 ncs_q;
  logic [2:0]                 copi_q;
  logic [1:0]                 fill_q;
  logic                       armed_q;
  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [ADDR_W-1:0]          cmd_q, cmd_d;
  logic [DATA_W-1:0]          data_q, data_d;
  logic [DATA_W-1:0]          rd_q, rd_d;
  logic                       cipo_q, cipo_d;
  logic                       cipo_oe_q, cipo_oe_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]        strobe_q, strobe_d;
  logic                       err_q, err_d;

  logic sclk_rise_s, sclk_fall_s, ncs_fall_s, ncs_rise_s;
  logic [CNT_W-1:0] count_inc_s;

  // armed_q stays low until a genuine high nCS sample is seen after reset,
  // so a frame already in progress at reset release cannot start a transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q  <= 3'b000;
      ncs_q   <= 3'b111;
      copi_q  <= 3'b000;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[1:0], SCLK};
      ncs_q   <= {ncs_q[1:0], nCS};
      copi_q  <= {copi_q[1:0], COPI};
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & ncs_q[1]);
    end
  end

  assign sclk_rise_s = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_s = ~sclk_q[1] & sclk_q[2];
  assign ncs_fall_s  = armed_q & ~ncs_q[1] & ncs_q[2];
  assign ncs_rise_s  = ncs_q[1] & ~ncs_q[2];
  assign count_inc_s = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    rd_d      = rd_q;
    cipo_d    = cipo_q;
    regs_d    = regs_q;
    strobe_d  = '0;
    err_d     = 1'b0;
    cipo_oe_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ncs_fall_s) begin
          state_d = S_CMD;
          count_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMD: begin
        if (ncs_rise_s) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise_s) begin
          count_d = count_inc_s;
          cmd_d   = {cmd_q[ADDR_W-2:0], copi_q[2]};
          if (count_q == CNT_CMD_LAST) begin
            // The R/W bit has just shifted out of cmd_q; cmd_d now holds the address.
            if (cmd_q[ADDR_W-1]) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_RDATA;
              rd_d    = in_range(cmd_d) ? reg_lookup(cmd_d, regs_q) : '0;
            end
          end else begin
            state_d = S_CMD;
          end
        end else begin
          state_d = S_CMD;
        end
      end
      S_WDATA: begin
        if (ncs_rise_s) begin
          if ((count_q == CNT_LEN) && in_range(cmd_q)) begin
            state_d  = S_COMMIT;
            regs_d   = reg_write(regs_q, cmd_q, data_q);
            strobe_d = onehot(cmd_q);
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end else if (sclk_rise_s) begin
          count_d = count_inc_s;
          if (count_q < CNT_LEN) begin
            data_d = {data_q[DATA_W-2:0], copi_q[2]};
          end else begin
            data_d = data_q;
          end
        end else begin
          state_d = S_WDATA;
        end
      end
      S_RDATA: begin
        if (ncs_rise_s) begin
          state_d = S_IDLE;
          err_d   = (count_q != CNT_LEN);
        end else begin
          if (sclk_rise_s) begin
            count_d = count_inc_s;
          end else begin
            count_d = count_q;
          end
          if (sclk_fall_s) begin
            cipo_d = rd_q[DATA_W-1];
            rd_d   = {rd_q[DATA_W-2:0], 1'b0};
          end else begin
            cipo_d = cipo_q;
          end
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_RDATA) begin
      cipo_oe_d = 1'b1;
    end else begin
      cipo_oe_d = 1'b0;
      cipo_d    = 1'b0;
    end
  end

  // Frame state, shifters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      rd_q      <= '0;
      cipo_q    <= 1'b0;
      cipo_oe_q <= 1'b0;
      regs_q    <= '0;
      strobe_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
      cipo_q    <= cipo_d;
      cipo_oe_q <= cipo_oe_d;
      regs_q    <= regs_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
    end
  end

  assign CIPO      = cipo_q;
  assign CIPO_oe   = cipo_oe_q;
  assign regs      = regs_q;
  assign wr_strobe = strobe_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_peripheral_rw.sv
// Directed bench for spi_peripheral_rw: register model, read-data scoreboard,
// and pulse monitors for wr_strobe / frame_err.
module tb_spi_peripheral_rw;

  localparam int DW   = 8;
  localparam int AW   = 7;
  localparam int NR   = 5;
  localparam int HALF = 80;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              SCLK;
  logic              nCS;
  logic              COPI;
  logic              CIPO;
  logic              CIPO_oe;
  logic [NR*DW-1:0]  regs;
  logic [NR-1:0]     wr_strobe;
  logic              frame_err;

  int vectors     = 0;
  int miscompares = 0;
  int err_cnt     = 0;
  int cipo_bad    = 0;

  logic [NR-1:0] strobe_log[$];
  logic          exp_q[$];
  logic [NR*DW-1:0] mdl;

  int s0, e0, c0;

  spi_peripheral_rw #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SCLK      (SCLK),
    .nCS       (nCS),
    .COPI      (COPI),
    .CIPO      (CIPO),
    .CIPO_oe   (CIPO_oe),
    .regs      (regs),
    .wr_strobe (wr_strobe),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe !== '0) strobe_log.push_back(wr_strobe);
    if (frame_err === 1'b1) err_cnt++;
    if (CIPO_oe !== 1'b1 && CIPO !== 1'b0) cipo_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic smp, input string tag);
    logic e;
    COPI = b;
    #HALF;
    SCLK = 1'b1;
    #HALF;
    SCLK = 1'b0;
    if (smp) begin
      #50;
      chk({tag, " oe"}, 64'(CIPO_oe), 64'(1'b1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, " cipo"}, 64'(CIPO), 64'(e));
      end else begin
        chk({tag, " scoreboard underflow"}, 64'(1'b1), 64'(1'b0));
      end
    end
  endtask

  task automatic frame(input logic [15:0] f, input int nbits, input logic rd, input string tag);
    logic b;
    nCS = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? f[15 - i] : 1'b0;
      send_bit(b, rd && (i >= 7) && (i <= 14), tag);
    end
    #HALF;
    nCS = 1'b1;
    #200;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int nbits,
                          input string tag);
    frame({1'b1, a, d}, nbits, 1'b0, tag);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] expd, input string tag);
    for (int i = 0; i < DW; i++) exp_q.push_back(expd[DW-1-i]);
    frame({1'b0, a, 8'h00}, 16, 1'b1, tag);
    chk({tag, " scoreboard drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [NR-1:0] strobe_at(input int idx);
    strobe_at = (strobe_log.size() > idx) ? strobe_log[idx] : '0;
  endfunction

  task automatic snap();
    s0 = strobe_log.size();
    e0 = err_cnt;
  endtask

  initial begin
    SCLK  = 1'b0;
    nCS   = 1'b1;
    COPI  = 1'b0;
    rst_n = 1'b0;
    mdl   = '0;
    repeat (4) @(negedge clk);
    chk("reset regs", 64'(regs), 64'(mdl));
    chk("reset strobe", 64'(wr_strobe), 64'd0);
    chk("reset err", 64'(frame_err), 64'd0);
    chk("reset cipo", 64'(CIPO), 64'd0);
    chk("reset cipo_oe", 64'(CIPO_oe), 64'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // T1
    snap();
    do_write(7'h01, 8'hA5, 16, "T1");
    mdl[1*DW +: DW] = 8'hA5;
    chk("T1 regs", 64'(regs), 64'(mdl));
    chk("T1 strobe count", 64'(strobe_log.size() - s0), 64'd1);
    chk("T1 strobe", 64'(strobe_at(s0)), 64'(5'b00010));
    chk("T1 err", 64'(err_cnt - e0), 64'd0);

    // T2
    do_write(7'h03, 8'h3C, 16, "T2 preload");
    mdl[3*DW +: DW] = 8'h3C;
    chk("T2 preload regs", 64'(regs), 64'(mdl));
    snap();
    do_read(7'h03, 8'h3C, "T2 read");
    chk("T2 regs unchanged", 64'(regs), 64'(mdl));
    chk("T2 no strobe", 64'(strobe_log.size() - s0), 64'd0);
    chk("T2 err", 64'(err_cnt - e0), 64'd0);
    do_read(7'h01, 8'hA5, "T2 read1");

    // T3
    snap();
    do_write(7'h07, 8'hFF, 16, "T3 write");
    chk("T3 regs", 64'(regs), 64'(mdl));
    chk("T3 no strobe", 64'(strobe_log.size() - s0), 64'd0);
    chk("T3 err", 64'(err_cnt - e0), 64'd1);
    snap();
    do_read(7'h07, 8'h00, "T3 read");
    chk("T3 read err", 64'(err_cnt - e0), 64'd0);

    // T4
    snap();
    do_write(7'h02, 8'h5A, 12, "T4 short");
    chk("T4 short regs", 64'(regs), 64'(mdl));
    chk("T4 short err", 64'(err_cnt - e0), 64'd1);
    snap();
    do_write(7'h02, 8'h5A, 17, "T4 long");
    chk("T4 long regs", 64'(regs), 64'(mdl));
    chk("T4 long err", 64'(err_cnt - e0), 64'd1);
    chk("T4 no strobe", 64'(strobe_log.size() - s0), 64'd0);
    snap();
    do_write(7'h02, 8'h5A, 16, "T4 valid");
    mdl[2*DW +: DW] = 8'h5A;
    chk("T4 valid regs", 64'(regs), 64'(mdl));
    chk("T4 valid strobe", 64'(strobe_at(s0)), 64'(5'b00100));

    // T5
    snap();
    nCS = 1'b0;
    #HALF;
    for (int i = 0; i < 10; i++) send_bit(((16'h8077 >> (15 - i)) & 16'h1) != 16'h0, 1'b0, "T5");
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    mdl = '0;
    chk("T5 reset regs", 64'(regs), 64'(mdl));
    chk("T5 reset cipo_oe", 64'(CIPO_oe), 64'd0);
    rst_n = 1'b1;
    for (int i = 10; i < 16; i++) send_bit(((16'h8077 >> (15 - i)) & 16'h1) != 16'h0, 1'b0, "T5");
    #HALF;
    nCS = 1'b1;
    #200;
    chk("T5 regs after", 64'(regs), 64'(mdl));
    chk("T5 no strobe", 64'(strobe_log.size() - s0), 64'd0);
    chk("T5 no err", 64'(err_cnt - e0), 64'd0);
    snap();
    do_write(7'h02, 8'h99, 16, "T5 valid");
    mdl[2*DW +: DW] = 8'h99;
    chk("T5 valid regs", 64'(regs), 64'(mdl));
    chk("T5 valid strobe", 64'(strobe_at(s0)), 64'(5'b00100));

    // T6: 2-SCLK-period nCS gap between frames
    snap();
    nCS = 1'b0;
    #HALF;
    for (int i = 0; i < 16; i++) send_bit(((16'h8011 >> (15 - i)) & 16'h1) != 16'h0, 1'b0, "T6a");
    #HALF;
    nCS = 1'b1;
    #(4 * HALF);
    nCS = 1'b0;
    #HALF;
    for (int i = 0; i < 16; i++) send_bit(((16'h8444 >> (15 - i)) & 16'h1) != 16'h0, 1'b0, "T6b");
    #HALF;
    nCS = 1'b1;
    #200;
    mdl[0*DW +: DW] = 8'h11;
    mdl[4*DW +: DW] = 8'h44;
    chk("T6 regs", 64'(regs), 64'(mdl));
    chk("T6 strobe count", 64'(strobe_log.size() - s0), 64'd2);
    chk("T6 strobe first", 64'(strobe_at(s0)), 64'(5'b00001));
    chk("T6 strobe second", 64'(strobe_at(s0 + 1)), 64'(5'b10000));
    chk("T6 err", 64'(err_cnt - e0), 64'd0);

    chk("cipo zero when not driven", 64'(cipo_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
